// File: rtl/slice_accumulator.sv
// ---------------------------------------------------------------------------
// slice_accumulator
//
// Sums a packed vector of LANES unsigned W-bit slices, P slices per clock,
// into an ACC_W-bit accumulator. The vector is taken in on a valid/ready
// handshake, and the total is presented with a sticky overflow flag on a
// second valid/ready handshake. The result is presented N = LANES/P cycles
// after acceptance. Only one vector is in flight at a time.
//
// Parameters
//   LANES  number of slices in the input vector
//   W      slice width in bits
//   P      slices added per cycle (must divide LANES)
//   ACC_W  accumulator / result width (must be >= W)
//
// Ports
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   in_data    packed slices, slice k = in_data[k*W +: W]
//   in_valid   in_data is valid
//   in_ready   block can accept a vector (registered)
//   sum        accumulated result (registered)
//   overflow   the true sum exceeded 2^ACC_W-1 (registered, sticky per vector)
//   out_valid  sum/overflow are valid (registered)
//   out_ready  downstream accepts the result
//
// Build option
//   SLICE_ACCUMULATOR_SATURATE_EN  defined: the accumulator clamps to
//                                  2^ACC_W-1 on overflow.
//                                  undefined: the accumulator wraps modulo
//                                  2^ACC_W.
//   overflow is reported identically in both builds.
// ---------------------------------------------------------------------------
module slice_accumulator #(
   parameter int LANES = 48,
   parameter int W     = 10,
   parameter int P     = 4,
   parameter int ACC_W = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [LANES*W-1:0]   in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [ACC_W-1:0]     sum,
   output logic                 overflow,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int N     = LANES / P;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   // Headroom for the accumulator plus P slices of at most W <= ACC_W bits.
   localparam int PW    = ACC_W + $clog2(P) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   generate
      if ((LANES % P) != 0) begin : g_bad_p
         $error("slice_accumulator: P must divide LANES");
      end
      if (ACC_W < W) begin : g_bad_accw
         $error("slice_accumulator: ACC_W must be >= W");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t               state_reg;
   logic [LANES*W-1:0]   data_reg;
   logic [ACC_W-1:0]     acc_reg;
   logic [IDX_W-1:0]     idx_reg;
   logic                 ovf_reg;
   logic                 in_ready_reg;
   logic                 out_valid_reg;

   // Slices belonging to the group currently being processed.
   logic [W-1:0]         grp_slice [P];

   genvar gi;
   generate
      for (gi = 0; gi < P; gi++) begin : g_slice
         assign grp_slice[gi] = data_reg[(int'(idx_reg) * P + gi) * W +: W];
      end
   endgenerate

   logic [PW-1:0]        grp_sum;
   logic [PW-1:0]        partial_next;
   logic                 part_ovf;
   logic [ACC_W-1:0]     acc_next;

   always_comb begin
      grp_sum = '0;
      for (int i = 0; i < P; i++) begin
         grp_sum = grp_sum + PW'(grp_slice[i]);
      end
      partial_next = grp_sum + PW'(acc_reg);
      // Any bit above the accumulator width means the true sum no longer fits.
      part_ovf     = |partial_next[PW-1:ACC_W];
`ifdef SLICE_ACCUMULATOR_SATURATE_EN
      // Once clamped, later partials stay >= max, so the clamp is held.
      acc_next     = part_ovf ? {ACC_W{1'b1}} : partial_next[ACC_W-1:0];
`else
      acc_next     = partial_next[ACC_W-1:0];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         data_reg      <= '0;
         acc_reg       <= '0;
         idx_reg       <= '0;
         ovf_reg       <= 1'b0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  data_reg     <= in_data;
                  acc_reg      <= '0;
                  ovf_reg      <= 1'b0;
                  idx_reg      <= '0;
                  in_ready_reg <= 1'b0;
                  state_reg    <= ACCUM;
               end
            end
            ACCUM: begin
               acc_reg <= acc_next;
               if (part_ovf) begin
                  ovf_reg <= 1'b1;
               end
               idx_reg <= idx_reg + IDX_W'(1);
               if (idx_reg == LAST_IDX) begin
                  out_valid_reg <= 1'b1;
                  state_reg     <= DONE;
               end
            end
            DONE: begin
               // No new vector is taken here; in_ready only returns in IDLE.
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: begin
               out_valid_reg <= 1'b0;
               in_ready_reg  <= 1'b1;
               state_reg     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign sum       = acc_reg;
   assign overflow  = ovf_reg;

endmodule

// File: tb/tb_slice_accumulator.sv
// ---------------------------------------------------------------------------
// tb_slice_accumulator
//
// Drives three slice_accumulator instances with randomized and directed
// vectors and checks results against an arithmetic reference model:
//   dut 0: P=4,  ACC_W=10
//   dut 1: P=4,  ACC_W=16
//   dut 2: P=48, ACC_W=10
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_slice_accumulator;

   localparam int LANES = 48;
   localparam int W     = 10;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [LANES*W-1:0] in_data;
   logic               in_valid   [3];
   logic               out_ready  [3];
   logic               in_ready   [3];
   logic               out_valid  [3];
   logic               overflow_w [3];
   logic [9:0]         sum0;
   logic [15:0]        sum1;
   logic [9:0]         sum2;

   int total = 0;
   int bad   = 0;

   int accw [3] = '{10, 16, 10};
   int pp   [3] = '{4, 4, 48};

   slice_accumulator #(.LANES(LANES), .W(W), .P(4), .ACC_W(10)) u_d0 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid[0]),
      .in_ready(in_ready[0]), .sum(sum0), .overflow(overflow_w[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]));

   slice_accumulator #(.LANES(LANES), .W(W), .P(4), .ACC_W(16)) u_d1 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid[1]),
      .in_ready(in_ready[1]), .sum(sum1), .overflow(overflow_w[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]));

   slice_accumulator #(.LANES(LANES), .W(W), .P(48), .ACC_W(10)) u_d2 (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid[2]),
      .in_ready(in_ready[2]), .sum(sum2), .overflow(overflow_w[2]),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] get_sum(input int d);
      case (d)
         0:       return 32'(sum0);
         1:       return 32'(sum1);
         default: return 32'(sum2);
      endcase
   endfunction

   function automatic logic [LANES*W-1:0] rnd_vec(input int maxv);
      logic [LANES*W-1:0] v;
      for (int k = 0; k < LANES; k++) v[k*W +: W] = W'($urandom_range(0, maxv));
      return v;
   endfunction

   function automatic logic [LANES*W-1:0] const_vec(input int val);
      logic [LANES*W-1:0] v;
      for (int k = 0; k < LANES; k++) v[k*W +: W] = W'(val);
      return v;
   endfunction

   function automatic logic [LANES*W-1:0] ramp_vec();
      logic [LANES*W-1:0] v;
      for (int k = 0; k < LANES; k++) v[k*W +: W] = W'(k);
      return v;
   endfunction

   // Reference: exact integer total, then the configured wrap/clamp rule.
   task automatic model(input int d, input logic [LANES*W-1:0] v,
                        output logic [31:0] s, output logic o);
      longint t;
      longint mx;
      t = 0;
      for (int k = 0; k < LANES; k++) t += longint'(v[k*W +: W]);
      mx = (longint'(1) << accw[d]) - 1;
      o  = (t > mx);
`ifdef SLICE_ACCUMULATOR_SATURATE_EN
      s = o ? 32'(mx) : 32'(t);
`else
      s = 32'(t % (mx + 1));
`endif
   endtask

   task automatic wait_ready(input int d);
      int n;
      n = 0;
      while (!in_ready[d] && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("wait_ready", 32'(in_ready[d]), 32'd1);
   endtask

   // One full transaction; hold = backpressure cycles, poke = present a
   // second vector during DONE which must not be taken.
   task automatic run_vec(input int d, input logic [LANES*W-1:0] v,
                          input int hold, input bit poke, output logic [31:0] got);
      logic [31:0] es;
      logic        eo;
      int          cnt;
      wait_ready(d);
      in_data     = v;
      in_valid[d] = 1'b1;
      @(negedge clk);
      in_valid[d] = 1'b0;
      in_data     = rnd_vec(1023);
      cnt = 0;
      while (!out_valid[d] && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      model(d, v, es, eo);
      got = get_sum(d);
      chk("latency", 32'(cnt), 32'(LANES / pp[d]));
      chk("sum", got, es);
      chk("overflow", 32'(overflow_w[d]), 32'(eo));
      $display("vec dut=%0d sum=%0d ovf=%0b lat=%0d hold=%0d", d, got, overflow_w[d], cnt, hold);
      if (poke) in_valid[d] = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_sum", get_sum(d), es);
         chk("hold_ovf", 32'(overflow_w[d]), 32'(eo));
         chk("hold_valid", 32'(out_valid[d]), 32'd1);
         chk("hold_inrdy", 32'(in_ready[d]), 32'd0);
      end
      out_ready[d] = 1'b1;
      @(negedge clk);
      out_ready[d] = 1'b0;
      in_valid[d]  = 1'b0;
      chk("post_valid", 32'(out_valid[d]), 32'd0);
      chk("post_inrdy", 32'(in_ready[d]), 32'd1);
   endtask

   initial begin
      logic [31:0] got;
      int last;
      int accepted;
      for (int d = 0; d < 3; d++) begin
         in_valid[d]  = 1'b0;
         out_ready[d] = 1'b0;
      end
      in_data = '0;
      rst_n   = 1'b0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk("rst_inrdy", 32'(in_ready[d]), 32'd1);
         chk("rst_valid", 32'(out_valid[d]), 32'd0);
         chk("rst_sum", get_sum(d), 32'd0);
         chk("rst_ovf", 32'(overflow_w[d]), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases
      run_vec(0, const_vec(1), 0, 1'b0, got);
      chk("ones_p4", got, 32'd48);
      run_vec(0, const_vec(1023), 0, 1'b0, got);
`ifdef SLICE_ACCUMULATOR_SATURATE_EN
      chk("full_p4", got, 32'd1023);
`else
      chk("full_p4", got, 32'd976);
`endif
      chk("full_p4_ovf", 32'(overflow_w[0]), 32'd1);
      run_vec(1, const_vec(1023), 0, 1'b0, got);
      chk("full_w16", got, 32'd49104);
      run_vec(0, ramp_vec(), 0, 1'b0, got);
`ifdef SLICE_ACCUMULATOR_SATURATE_EN
      chk("ramp", got, 32'd1023);
`else
      chk("ramp", got, 32'd104);
`endif
      run_vec(0, ramp_vec(), 5, 1'b1, got);
      run_vec(2, const_vec(2), 0, 1'b0, got);
      chk("single_cycle", got, 32'd96);

      // Reset in the middle of an accumulation
      wait_ready(0);
      in_data     = const_vec(7);
      in_valid[0] = 1'b1;
      @(negedge clk);
      in_valid[0] = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_inrdy", 32'(in_ready[0]), 32'd1);
      chk("mid_rst_valid", 32'(out_valid[0]), 32'd0);
      chk("mid_rst_sum", get_sum(0), 32'd0);
      chk("mid_rst_ovf", 32'(overflow_w[0]), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_vec(0, const_vec(1), 0, 1'b0, got);
      chk("after_rst", got, 32'd48);

      // Randomized transactions
      for (int it = 0; it < 8; it++) begin
         for (int d = 0; d < 3; d++) begin
            int sel;
            int mv;
            sel = $urandom_range(0, 3);
            mv  = (sel == 0) ? 1023 : (sel == 1) ? 40 : (sel == 2) ? 20 : 1;
            run_vec(d, rnd_vec(mv), $urandom_range(0, 3), 1'($urandom_range(0, 1)), got);
         end
      end

      // Back-to-back on the single-cycle instance: one accept every 3 cycles
      in_data      = const_vec(2);
      in_valid[2]  = 1'b1;
      out_ready[2] = 1'b1;
      last     = -1;
      accepted = 0;
      for (int cyc = 0; cyc < 15; cyc++) begin
         @(negedge clk);
         if (in_ready[2]) begin
            if (last >= 0) chk("b2b_gap", 32'(cyc - last), 32'd3);
            last = cyc;
            accepted++;
         end
         if (out_valid[2]) chk("b2b_sum", get_sum(2), 32'd96);
      end
      chk("b2b_count", 32'(accepted), 32'd5);
      in_valid[2] = 1'b0;
      repeat (4) @(negedge clk);
      out_ready[2] = 1'b0;
      chk("b2b_idle", 32'(in_ready[2]), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/slice_accumulator.md
# slice_accumulator

Sequential, parametrised successor to the combinational slice-sum block. Accepts a packed vector of LANES unsigned W-bit slices via valid/ready handshake, sums P slices per clock into an ACC_W-bit accumulator, and presents the total with an overflow flag on a second valid/ready handshake. Used in triplicated datapaths where a single-cycle 48-way adder tree does not close timing; the default `tmrg` triplicate policy applies.

## Interface

- LANES, 48: number of slices in the input vector.
- W, 10: slice width in bits.
- P, 4: slices added per cycle; must divide LANES (elaboration error otherwise).
- ACC_W, 10: accumulator and result width; must be ≥ W.
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  LANES*W  slice k is `in_data[k*W +: W]`.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a vector.
- sum  output  ACC_W  result.
- overflow  output  1  true sum exceeded 2^ACC_W−1.
- out_valid  output  1  sum and overflow are valid.
- out_ready  input  1  downstream accepts the result.

## Operation

- FSM states: IDLE, ACCUM, DONE.
- IDLE: in_ready=1. When in_valid=1 at an edge, latch in_data, clear acc, overflow and idx, then go to ACCUM.
- ACCUM: in_ready=0. Each edge adds slices idx*P … idx*P+P−1 to acc, then increments idx. The partial sum is computed at ACC_W+$clog2(P)+1 bits.
  - If the partial sum exceeds 2^ACC_W−1, set overflow (sticky) and apply the Configuration rule.
  - After the edge that processes idx=LANES/P−1, go to DONE.
- DONE: out_valid=1; sum=acc; overflow held. Stay until out_ready=1 at an edge, then go to IDLE. No new vector is accepted in DONE (no overlap).
- Slices are unsigned. There is no signed mode.
- Reset (any state, including mid-ACCUM): state=IDLE, acc=0, idx=0, overflow=0, latched data=0.
  - Reset values: in_ready=1, out_valid=0, sum=0, overflow=0.
  - A partial accumulation is discarded and no result is produced.

## Timing

- N = LANES/P.
- Acceptance edge e0. ACCUM edges are e1…eN. out_valid rises after eN, so latency is N cycles from acceptance.
- With P=LANES: N=1, and out_valid is high on the cycle after acceptance.
- in_ready returns high the cycle after the out handshake edge.
- Minimum period between accepted vectors is N+2 cycles.
- in_data may change after e0 with no effect on the result.
- sum, overflow and out_valid are stable while out_valid=1 and out_ready=0.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration

- Macro: SLICE_ACCUMULATOR_SATURATE_EN.
- Defined: on overflow, acc clamps to 2^ACC_W−1 and stays there for the rest of the vector.
- Undefined: acc keeps the low ACC_W bits (modulo 2^ACC_W). This is bit-identical to the previous generation's `a += slice` behaviour.
- overflow is reported identically in both builds.

## Test plan

All cases use LANES=48, W=10 unless stated.

- **All ones.** P=4, ACC_W=10, all slices = 1 → sum=48, overflow=0. out_valid rises exactly 12 cycles after acceptance.
- **All full-scale.** P=4, ACC_W=10, all slices = 1023 (total 49104) → sum=976, overflow=1 without the macro; sum=1023, overflow=1 with it. With ACC_W=16: sum=49104, overflow=0 in both builds.
- **Ramp.** P=4, ACC_W=10, slice k = k (total 1128) → sum=104, overflow=1 without the macro; sum=1023 with it.
- **Backpressure.** P=4: hold out_ready=0 for 5 cycles after out_valid → sum, overflow and out_valid stay stable and in_ready=0. out_ready=1 → in_ready=1 the next cycle. A vector presented during DONE is not accepted.
- **Reset mid-ACCUM.** P=4: assert rst_n=0 at idx=5 → immediately in_ready=1, out_valid=0, sum=0, overflow=0. The next all-ones vector yields 48.
- **Single-cycle.** P=48, all slices = 2 → sum=96, out_valid high on the cycle after acceptance. Back-to-back vectors with out_ready=1 are accepted every 3 cycles.
